serial_port: RTL and testbench
==============================

# serial_port

Parametrised full-duplex UART for the `clk_50` CPU domain. It replaces the separate `serial_output`/`serial_input` pair on the debug link of `main_0`. The block adds a receive FIFO so bytes arriving while the CPU is busy are not lost, and it reports stop-bit framing errors and FIFO overflows. It is generalised in clock, baud rate and FIFO depth, and connects directly to the stb/ack debug streams of the control processor.

## Interface
- `clock_frequency`, 50000000: `clk` frequency in Hz.
- `baud_rate`, 115200: line rate in bits per second.
- `fifo_depth`, 16: receive FIFO entries. Must be a power of two, minimum 2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle level is high.
- `tx`  out  1  serial output; idle level is high.
- `in1`  in  8  byte to transmit.
- `in1_stb`  in  1  producer has a valid byte on `in1`.
- `in1_ack`  out  1  byte accepted this cycle.
- `out1`  out  8  received byte at the FIFO head.
- `out1_stb`  out  1  FIFO is not empty.
- `out1_ack`  in  1  consumer takes the byte on `out1`.
- `rx_count`  out  clog2(fifo_depth)+1  current FIFO occupancy.
- `rx_overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `rx_framing_error`  out  1  one-cycle pulse: a received stop bit was low.

## Operation
- Bit period: `DIV = clock_frequency / baud_rate`, integer division rounding down. `DIV` must be at least 4; elaboration fails otherwise.
- Frame format: 1 start bit (low), 8 data bits LSB first, optional parity bit (see Configuration), 1 stop bit (high).
- Handshake rule on both streams: a transfer occurs on any cycle where stb and ack are both high.
- TX state machine: IDLE → START → DATA(8) → [PARITY] → STOP → IDLE.
  - In IDLE with `in1_stb` high: `in1_ack` is driven high for exactly one cycle, `in1` is latched and the machine enters START.
  - `in1_ack` is low in every other state.
  - Each state after IDLE lasts `DIV` cycles.
- RX path: `rx` passes through a 2-flop synchroniser. The RX state machine is IDLE → START → DATA(8) → [PARITY] → STOP → IDLE.
  - IDLE → START on a high-to-low transition of the synchronised input.
  - START samples at `DIV/2` cycles. If the line is high, the event is a glitch and the machine returns to IDLE with no error.
  - Each following bit is sampled `DIV` cycles after the previous sample.
  - STOP sample low: the byte is discarded, `rx_framing_error` pulses, and the machine returns to IDLE.
  - STOP sample high: the byte is pushed into the FIFO. The machine then waits in IDLE for the line to go high before it re-arms.
- FIFO:
  - A push is allowed when the FIFO is not full, or when a pop happens in the same cycle.
  - A push into a full FIFO with no pop drops the byte and sets `rx_overflow`. `rx_overflow` clears only on `rst`.
  - Read and write pointers wrap modulo `fifo_depth`. A simultaneous push and pop leaves `rx_count` unchanged.
- Reset (synchronous, takes effect mid-frame):
  - Both state machines go to IDLE and the FIFO is emptied.
  - `tx`=1, `in1_ack`=0, `out1_stb`=0, `out1`=0, `rx_count`=0, `rx_overflow`=0, `rx_framing_error`=0.
  - An in-flight TX frame is truncated with the line high.

## Timing
- `tx` falls on the cycle after the cycle with `in1_ack` high.
- Frame length is `10*DIV` cycles, or `11*DIV` with parity. The next `in1_ack` can occur at the earliest on the first cycle back in IDLE.
- Receive latency: the FIFO write happens 1 cycle after the stop-bit sample. `out1_stb` and `out1` are valid on the cycle after the write.
- `out1` always shows the FIFO head combinationally from registered storage. After a pop, the next entry appears on the following cycle.
- `rx_count` updates on the cycle after each push or pop.
- Start-edge detection lags the pin by 2–3 cycles because of the synchroniser. The mid-bit sampling point absorbs this.

## Configuration
- Macro: `SERIAL_PORT_PARITY_EN`.
- Defined:
  - TX appends an even parity bit after D7.
  - RX checks the parity bit. On a mismatch the byte is discarded and `rx_framing_error` pulses.
  - Frames are 11 bits.
- Undefined: no PARITY state exists on either side, and frames are 10 bits.

## Structure
- Package `serial_port_pkg` holds:
  - the TX and RX state enums;
  - the `DIV` calculation function;
  - the frame-length constant, which depends on the macro.
- Sub-module `serial_port_fifo` holds the synchronous RAM FIFO with push, pop, full, empty and count. The UART state machines stay in `serial_port`.

## Test plan
All scenarios use `clock_frequency`=1000000 and `baud_rate`=100000, giving `DIV`=10.
- Send 0xA5 on `in1`:
  - `in1_ack` goes high for 1 cycle;
  - `tx` then shows 0,1,0,1,0,0,1,0,1,1, each bit lasting 10 cycles;
  - the next ack comes no earlier than 100 cycles after the first.
- Drive the frame for 0x3C on `rx` with `out1_ack`=0: `out1_stb` rises 2 cycles after the stop-bit sample, with `out1`=0x3C and `rx_count`=1.
- Receive 17 bytes with `fifo_depth`=16 and no reads:
  - `rx_count`=16 and `rx_overflow`=1;
  - the first 16 bytes are read back in order, and byte 17 is absent.
- Send a frame with a low stop bit: `rx_framing_error` pulses once, `rx_count` stays 0, and the next valid frame is received correctly.
- Drive a 3-cycle low glitch on `rx`: no byte is received and no error is reported.
- Assert `rst` mid-TX-frame and mid-RX-frame with the FIFO holding 3 bytes: on the following cycle `tx`=1, `out1_stb`=0, `rx_count`=0 and `rx_overflow`=0.

Source files
------------

// File: rtl/serial_port_pkg.sv
// Shared types and constants for serial_port. Frame layout depends on the
// SERIAL_PORT_PARITY_EN macro (even parity bit after D7 when defined).
package serial_port_pkg;

`ifdef SERIAL_PORT_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    localparam int FRAME_BITS = 10;
`endif

    function automatic int calc_div(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/serial_port_fifo.sv
// Receive FIFO for serial_port: registered storage, power-of-two depth,
// push accepted when not full or when a pop happens in the same cycle.
module serial_port_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("serial_port_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_port.sv
// Full-duplex UART with receive FIFO, framing and overflow reporting.
// Define SERIAL_PORT_PARITY_EN to add an even parity bit to both directions.
module serial_port
    import serial_port_pkg::*;
#(
    parameter int clock_frequency = 50000000,
    parameter int baud_rate       = 115200,
    parameter int fifo_depth      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    input  logic [7:0]                    in1,
    input  logic                          in1_stb,
    output logic                          in1_ack,
    output logic [7:0]                    out1,
    output logic                          out1_stb,
    input  logic                          out1_ack,
    output logic [$clog2(fifo_depth):0]   rx_count,
    output logic                          rx_overflow,
    output logic                          rx_framing_error
);
    localparam int DIV   = calc_div(clock_frequency, baud_rate);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);

    if (DIV < 4) begin : g_div_check
        $error("serial_port: clock_frequency / baud_rate must be at least 4");
    end

    tx_state_t               tx_state;
    logic [CNT_W-1:0]        tx_cnt;
    logic [2:0]              tx_bit;
    logic [FRAME_BITS-1:0]   tx_frame;

    rx_state_t               rx_state;
    logic [CNT_W-1:0]        rx_cnt;
    logic [2:0]              rx_bit;
    logic                    rx_s1;
    logic                    rx_s2;
    logic                    rx_prev;
    logic [7:0]              rx_shift;
    logic                    rx_push;
    logic                    fifo_full;
    logic                    fifo_empty;
`ifdef SERIAL_PORT_PARITY_EN
    logic                    rx_par;
`endif

    // The whole frame is loaded at accept time and shifted out LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= 1'b1;
            in1_ack  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (in1_ack) begin
                        in1_ack <= 1'b0;
                        if (in1_stb) begin
`ifdef SERIAL_PORT_PARITY_EN
                            tx_frame <= {1'b1, ^in1, in1, 1'b0};
`else
                            tx_frame <= {1'b1, in1, 1'b0};
`endif
                            tx       <= 1'b0;
                            tx_cnt   <= '0;
                            tx_state <= TX_START;
                        end
                    end else begin
                        in1_ack <= in1_stb;
                    end
                end
                default: begin
                    if (tx_cnt != BIT_END) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        tx_cnt   <= '0;
                        tx_frame <= tx_frame >> 1;
                        tx       <= tx_frame[1];
                        case (tx_state)
                            TX_START: begin
                                tx_bit   <= '0;
                                tx_state <= TX_DATA;
                            end
                            TX_DATA: begin
                                if (tx_bit == 3'd7)
`ifdef SERIAL_PORT_PARITY_EN
                                    tx_state <= TX_PARITY;
`else
                                    tx_state <= TX_STOP;
`endif
                                else
                                    tx_bit <= tx_bit + 1'b1;
                            end
`ifdef SERIAL_PORT_PARITY_EN
                            TX_PARITY: tx_state <= TX_STOP;
`endif
                            TX_STOP: begin
                                tx       <= 1'b1;
                                tx_state <= TX_IDLE;
                            end
                            default: tx_state <= TX_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // A falling edge needs a prior high sample, so after a stop bit the
    // receiver only re-arms once the line has returned high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1            <= 1'b1;
            rx_s2            <= 1'b1;
            rx_prev          <= 1'b1;
            rx_state         <= RX_IDLE;
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_push          <= 1'b0;
            rx_framing_error <= 1'b0;
        end else begin
            rx_s1            <= rx;
            rx_s2            <= rx_s1;
            rx_prev          <= rx_s2;
            rx_push          <= 1'b0;
            rx_framing_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt != HALF_END) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != BIT_END) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7)
`ifdef SERIAL_PORT_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end
                end
`ifdef SERIAL_PORT_PARITY_EN
                RX_PARITY: begin
                    if (rx_cnt != BIT_END) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_s2;
                        rx_state <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt != BIT_END) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
`ifdef SERIAL_PORT_PARITY_EN
                        if (!rx_s2 || (^{rx_shift, rx_par}))
`else
                        if (!rx_s2)
`endif
                            rx_framing_error <= 1'b1;
                        else
                            rx_push <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rx_overflow <= 1'b0;
        else if (rx_push && fifo_full && !out1_ack)
            rx_overflow <= 1'b1;
    end

    serial_port_fifo #(
        .DEPTH  (fifo_depth),
        .DATA_W (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_push),
        .wr_data (rx_shift),
        .pop     (out1_ack),
        .rd_data (out1),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (rx_count)
    );

    assign out1_stb = !fifo_empty;

endmodule

// File: tb/tb_serial_port.sv
// Directed bench for serial_port at DIV=10 (1 MHz clock, 100 kbaud, 16-entry FIFO).
module tb_serial_port;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 16;
    localparam int DIV    = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       tx;
    logic [7:0] in1;
    logic       in1_stb;
    logic       in1_ack;
    logic [7:0] out1;
    logic       out1_stb;
    logic       out1_ack;
    logic [4:0] rx_count;
    logic       rx_overflow;
    logic       rx_framing_error;

    int n_vec = 0;
    int n_bad = 0;

    serial_port #(
        .clock_frequency (CLK_HZ),
        .baud_rate       (BAUD),
        .fifo_depth      (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx               (rx),
        .tx               (tx),
        .in1              (in1),
        .in1_stb          (in1_stb),
        .in1_ack          (in1_ack),
        .out1             (out1),
        .out1_stb         (out1_stb),
        .out1_ack         (out1_ack),
        .rx_count         (rx_count),
        .rx_overflow      (rx_overflow),
        .rx_framing_error (rx_framing_error)
    );

    always #5 clk = ~clk;

    // Drives one 10-bit frame on rx, reporting when out1_stb first rose and
    // how many framing-error pulses were seen.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              output int stb_at, output int ferr_cnt);
        logic [9:0] bits;
        bits     = {stop_bit, data, 1'b0};
        stb_at   = -1;
        ferr_cnt = 0;
        for (int c = 0; c < 10*DIV + 4; c++) begin
            @(negedge clk);
            if (out1_stb && stb_at < 0) stb_at = c;
            if (rx_framing_error) ferr_cnt++;
            rx = (c < 10*DIV) ? bits[c/DIV] : 1'b1;
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        out1_ack = 1'b1;
        @(negedge clk);
        out1_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_vec++; if (in1_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", in1_ack); end
        n_vec++; if (out1_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", out1_stb); end
        n_vec++; if (out1 !== 8'h00) begin n_bad++; $display("FAIL reset_out1: got %h want 00", out1); end
        n_vec++; if (rx_count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", rx_count); end
        n_vec++; if (rx_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", rx_overflow); end
        n_vec++; if (rx_framing_error !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", rx_framing_error); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tx();
        logic [9:0] exp_bits;
        int waited;
        int early_acks;
        int gap;
        exp_bits   = {1'b1, 8'hA5, 1'b0};
        early_acks = 0;
        in1        = 8'hA5;
        in1_stb    = 1'b1;
        waited     = 0;
        do begin @(negedge clk); waited++; end while (!in1_ack && waited < 20);
        n_vec++; if (in1_ack !== 1'b1) begin n_bad++; $display("FAIL tx_first_ack: got %b want 1", in1_ack); end
        // Producer keeps stb high, so the next ack marks the earliest re-accept.
        for (int c = 1; c <= 10*DIV; c++) begin
            @(negedge clk);
            if (in1_ack) early_acks++;
            if ((c-1) % DIV == 0 || (c-1) % DIV == DIV-1) begin
                n_vec++;
                if (tx !== exp_bits[(c-1)/DIV]) begin
                    n_bad++;
                    $display("FAIL tx_bit%0d_cyc%0d: got %b want %b", (c-1)/DIV, c, tx, exp_bits[(c-1)/DIV]);
                end
            end
        end
        n_vec++; if (early_acks != 0) begin n_bad++; $display("FAIL tx_ack_during_frame: got %0d acks want 0", early_acks); end
        gap = 10*DIV;
        do begin @(negedge clk); gap++; end while (!in1_ack && gap < 10*DIV + 20);
        n_vec++; if (in1_ack !== 1'b1 || gap < 10*DIV) begin n_bad++; $display("FAIL tx_next_ack: ack %b after %0d cycles, want ack after >= 100", in1_ack, gap); end
        @(negedge clk);
        in1_stb = 1'b0;
        n_vec++; if (in1_ack !== 1'b0) begin n_bad++; $display("FAIL tx_ack_width: got %b want 0", in1_ack); end
        n_vec++; if (tx !== 1'b0) begin n_bad++; $display("FAIL tx_second_start: got %b want 0", tx); end
        repeat (10*DIV + 5) @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_idle_after: got %b want 1", tx); end
    endtask

    task automatic test_rx();
        int stb_at;
        int ferr;
        out1_ack = 1'b0;
        send_frame(8'h3C, 1'b1, stb_at, ferr);
        n_vec++; if (stb_at < 97 || stb_at > 101) begin n_bad++; $display("FAIL rx_latency: stb rose at cycle %0d want 97..101", stb_at); end
        n_vec++; if (out1 !== 8'h3C) begin n_bad++; $display("FAIL rx_data: got %h want 3c", out1); end
        n_vec++; if (rx_count !== 5'd1) begin n_bad++; $display("FAIL rx_count: got %0d want 1", rx_count); end
        n_vec++; if (ferr != 0) begin n_bad++; $display("FAIL rx_no_ferr: got %0d pulses want 0", ferr); end
        pop_one();
        n_vec++; if (rx_count !== 5'd0 || out1_stb !== 1'b0) begin n_bad++; $display("FAIL rx_pop: count %0d stb %b want 0 0", rx_count, out1_stb); end
    endtask

    task automatic test_framing();
        int stb_at;
        int ferr;
        send_frame(8'h77, 1'b0, stb_at, ferr);
        n_vec++; if (ferr != 1) begin n_bad++; $display("FAIL ferr_pulses: got %0d want 1", ferr); end
        n_vec++; if (rx_count !== 5'd0 || stb_at != -1) begin n_bad++; $display("FAIL ferr_discard: count %0d stb_at %0d want 0 -1", rx_count, stb_at); end
        send_frame(8'h5A, 1'b1, stb_at, ferr);
        n_vec++; if (out1 !== 8'h5A || rx_count !== 5'd1) begin n_bad++; $display("FAIL ferr_recover: out1 %h count %0d want 5a 1", out1, rx_count); end
        n_vec++; if (ferr != 0) begin n_bad++; $display("FAIL ferr_recover_clean: got %0d pulses want 0", ferr); end
        pop_one();
    endtask

    task automatic test_glitch();
        int ferr;
        int stb_seen;
        ferr     = 0;
        stb_seen = 0;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        for (int c = 0; c < 12*DIV; c++) begin
            @(negedge clk);
            if (rx_framing_error) ferr++;
            if (out1_stb) stb_seen++;
        end
        n_vec++; if (ferr != 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr); end
        n_vec++; if (stb_seen != 0 || rx_count !== 5'd0) begin n_bad++; $display("FAIL glitch_byte: stb cycles %0d count %0d want 0 0", stb_seen, rx_count); end
    endtask

    task automatic test_overflow();
        int stb_at;
        int ferr;
        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), 1'b1, stb_at, ferr);
        n_vec++; if (rx_count !== 5'd16 || rx_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_full: count %0d ovf %b want 16 0", rx_count, rx_overflow); end
        send_frame(8'hEE, 1'b1, stb_at, ferr);
        n_vec++; if (rx_count !== 5'd16 || rx_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_drop: count %0d ovf %b want 16 1", rx_count, rx_overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (out1 !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL ovf_read%0d: got %h want %h", i, out1, 8'(8'h10 + i)); end
            pop_one();
        end
        n_vec++; if (out1_stb !== 1'b0 || rx_count !== 5'd0) begin n_bad++; $display("FAIL ovf_empty: stb %b count %0d want 0 0", out1_stb, rx_count); end
        n_vec++; if (rx_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", rx_overflow); end
    endtask

    task automatic test_reset_mid();
        int stb_at;
        int ferr;
        int acked;
        send_frame(8'h01, 1'b1, stb_at, ferr);
        send_frame(8'h02, 1'b1, stb_at, ferr);
        send_frame(8'h03, 1'b1, stb_at, ferr);
        n_vec++; if (rx_count !== 5'd3) begin n_bad++; $display("FAIL mid_fill: got %0d want 3", rx_count); end
        @(negedge clk);
        in1     = 8'h00;
        in1_stb = 1'b1;
        rx      = 1'b0;
        acked   = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (acked == 1) begin in1_stb = 1'b0; acked = 2; end
            if (in1_ack && acked == 0) acked = 1;
        end
        n_vec++; if (tx !== 1'b0) begin n_bad++; $display("FAIL mid_tx_busy: got %b want 0", tx); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_bad++; $display("FAIL mid_reset_tx: got %b want 1", tx); end
        n_vec++; if (out1_stb !== 1'b0 || out1 !== 8'h00) begin n_bad++; $display("FAIL mid_reset_out: stb %b out1 %h want 0 00", out1_stb, out1); end
        n_vec++; if (rx_count !== 5'd0) begin n_bad++; $display("FAIL mid_reset_count: got %0d want 0", rx_count); end
        n_vec++; if (rx_overflow !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ovf: got %b want 0", rx_overflow); end
        n_vec++; if (in1_ack !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ack: got %b want 0", in1_ack); end
        rst     = 1'b0;
        rx      = 1'b1;
        in1_stb = 1'b0;
        repeat (12*DIV) @(negedge clk);
        n_vec++; if (tx !== 1'b1 || rx_count !== 5'd0) begin n_bad++; $display("FAIL mid_after: tx %b count %0d want 1 0", tx, rx_count); end
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        in1      = 8'h00;
        in1_stb  = 1'b0;
        out1_ack = 1'b0;
        test_reset();
        test_tx();
        test_rx();
        test_framing();
        test_glitch();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
